// File: rtl/cnn_acc_requant_22s_14s.sv
// rtl/cnn_acc_requant_22s_14s.sv - product accumulator with bias, round/shift/relu/saturate requant to 14s
module cnn_acc_requant_22s_14s #(
    parameter int N_ACC = 9,
    parameter int ACC_W = 32,
    parameter int SHIFT = 4,
    parameter int RELU  = 1
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic signed [21:0] prod_data,
    input  logic               prod_valid,
    output logic               prod_ready,
    input  logic signed [21:0] bias_data,
    output logic signed [13:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        grp_cnt
);

    localparam int CNT_W  = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [CNT_W-1:0]   LAST    = CNT_W'(N_ACC - 1);
    localparam logic signed [ACC_W:0] RND_ADD = (SHIFT > 0) ? ((ACC_W+1)'(1) <<< RND_SH) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(8191);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-8192);

    typedef enum logic [1:0] {S_ACC, S_RQ, S_OUT} state_t;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  prod_ext, bias_ext;
    logic signed [ACC_W:0]    acc_x, r;
    logic signed [13:0]       sat;
    logic                     beat;

    assign prod_ext = {{(ACC_W-22){prod_data[21]}}, prod_data};
    assign bias_ext = {{(ACC_W-22){bias_data[21]}}, bias_data};
    assign beat     = prod_valid && (state == S_ACC);

    always_comb begin
        state_nxt  = state;
        prod_ready = 1'b0;
        case (state)
            S_ACC: begin
                prod_ready = 1'b1;
                if (prod_valid && cnt == LAST) state_nxt = S_RQ;
            end
            S_RQ:  state_nxt = S_OUT;
            S_OUT: if (out_ready) state_nxt = S_ACC;
            default: state_nxt = S_ACC;
        endcase
    end

    // Rounding add carries one guard bit so acc near full scale cannot wrap.
    always_comb begin
        acc_x = {acc[ACC_W-1], acc};
        r     = acc_x;
        if (SHIFT > 0) r = (acc_x + RND_ADD) >>> SHIFT;
        if (RELU != 0 && r < 0) r = '0;
        if (r > SAT_MAX)      sat = 14'sd8191;
        else if (r < SAT_MIN) sat = -14'sd8192;
        else                  sat = r[13:0];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            grp_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                acc <= (cnt == '0) ? (bias_ext + prod_ext) : (acc + prod_ext);
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            if (state == S_RQ) begin
                out_data  <= sat;
                out_valid <= 1'b1;
                grp_cnt   <= grp_cnt + 16'd1;
            end
            if (state == S_OUT && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_acc_requant_22s_14s.sv
// tb/tb_cnn_acc_requant_22s_14s.sv - directed self-checking bench, RELU=0 and RELU=1 instances on shared inputs
module tb_cnn_acc_requant_22s_14s;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [21:0] prod_data;
    logic               prod_valid;
    logic signed [21:0] bias_data;
    logic               out_ready;
    logic               prod_ready, out_valid, prod_ready_r, out_valid_r;
    logic signed [13:0] out_data, out_data_r;
    logic [15:0]        grp_cnt, grp_cnt_r;

    int tests = 0;
    int fails = 0;
    int exp_grp = 0;

    always #5 clk = ~clk;

    cnn_acc_requant_22s_14s #(.N_ACC(4), .ACC_W(32), .SHIFT(4), .RELU(0)) dut (
        .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .bias_data(bias_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grp_cnt(grp_cnt));

    cnn_acc_requant_22s_14s #(.N_ACC(4), .ACC_W(32), .SHIFT(4), .RELU(1)) dut_relu (
        .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data), .prod_valid(prod_valid),
        .prod_ready(prod_ready_r), .bias_data(bias_data), .out_data(out_data_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .grp_cnt(grp_cnt_r));

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one group of four beats from negedge to negedge; gap inserts an idle cycle
    // before every beat and scrambles bias on non-first beats.
    task automatic send_group(input logic signed [21:0] b, input logic signed [21:0] p0,
                              input logic signed [21:0] p1, input logic signed [21:0] p2,
                              input logic signed [21:0] p3, input bit gap);
        logic signed [21:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                prod_valid = 1'b0;
                prod_data  = 22'sd12345;
                bias_data  = 22'sd777;
                @(negedge clk);
            end
            prod_valid = 1'b1;
            prod_data  = p[i];
            bias_data  = (i == 0) ? b : (gap ? 22'(-1000 * i) : b);
            @(negedge clk);
        end
        prod_valid = 1'b0;
        prod_data  = 'x;
    endtask

    // Called at the negedge after the last beat: checks the requant cycle, the result,
    // and (when out_ready is high) the return to accumulation.
    task automatic expect_out(input string tag, input int exp_d, input int exp_r);
        check({tag, ".rq_valid"}, 32'(out_valid), 0);
        check({tag, ".rq_ready"}, 32'(prod_ready), 0);
        @(negedge clk);
        exp_grp++;
        check({tag, ".valid"}, 32'(out_valid), 1);
        check({tag, ".data"}, 32'(out_data), exp_d);
        check({tag, ".data_relu"}, 32'(out_data_r), exp_r);
        check({tag, ".grp"}, 32'(grp_cnt), exp_grp & 16'hffff);
        if (out_ready) begin
            @(negedge clk);
            check({tag, ".done_valid"}, 32'(out_valid), 0);
            check({tag, ".done_ready"}, 32'(prod_ready), 1);
        end
    endtask

    initial begin
        rst = 1'b1; prod_valid = 1'b0; prod_data = '0; bias_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.out_data", 32'(out_data), 0);
        check("rst.grp_cnt", 32'(grp_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.prod_ready", 32'(prod_ready), 1);

        send_group(0, 100, 200, 300, 400, 0);
        expect_out("s1", 63, 63);

        send_group(0, 2097151, 2097151, 2097151, 2097151, 0);
        expect_out("s2.pos_sat", 8191, 8191);
        send_group(0, -2097152, -2097152, -2097152, -2097152, 0);
        expect_out("s2.neg_sat", -8192, 0);

        send_group(-40, 16, 0, 0, 0, 0);
        expect_out("s3", -1, 0);

        send_group(-8, 0, 0, 0, 0, 0);
        expect_out("half_neg", 0, 0);
        send_group(8, 0, 0, 0, 0, 0);
        expect_out("half_pos", 1, 1);

        out_ready = 1'b0;
        send_group(5, 10, 20, 30, 40, 0);
        expect_out("s4", 7, 7);
        prod_valid = 1'b1;
        prod_data  = 'x;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s4.hold_valid", 32'(out_valid), 1);
            check("s4.hold_data", 32'(out_data), 7);
            check("s4.hold_ready", 32'(prod_ready), 0);
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        check("s4.acc_valid", 32'(out_valid), 0);
        check("s4.acc_ready", 32'(prod_ready), 1);
        check("s4.grp", 32'(grp_cnt), exp_grp);

        prod_valid = 1'b1; bias_data = 22'sd1000; prod_data = 22'sd5000;
        repeat (2) @(negedge clk);
        prod_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_grp = 0;
        check("s5.rst_valid", 32'(out_valid), 0);
        check("s5.rst_grp", 32'(grp_cnt), 0);
        check("s5.rst_ready", 32'(prod_ready), 1);
        send_group(0, 16, 16, 16, 16, 0);
        expect_out("s5", 4, 4);

        send_group(0, 100, 200, 300, 400, 1);
        expect_out("s6", 63, 63);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
